// File: rtl/clk_check_pkg.sv
// Shared types and helpers for the divided-clock phase checker.
package clk_check_pkg;

    localparam int unsigned PHASE_W = 5;
    localparam int unsigned PERIOD  = 32;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_e;

    // Sampled clock levels ordered {clk_f, clk_2f, clk_4f}.
    typedef logic [2:0] triple_t;

    // Expected {f, 2f, 4f} levels at phase p: {~p[4], ~p[3], ~p[2]}.
    function automatic triple_t expected_triple(input logic [PHASE_W-1:0] p);
        return ~triple_t'(p >> 2);
    endfunction

endpackage

// File: rtl/clk_edge_sampler.sv
// Registers the three divided clocks in the clk_32f domain and flags the clk_f rising edge.
// The divided clocks come from the same clk_32f, so a single register stage is enough.
module clk_edge_sampler
    import clk_check_pkg::*;
(
    input  logic    clk_32f,
    input  logic    reset,
    input  logic    clk_4f_i,
    input  logic    clk_2f_i,
    input  logic    clk_f_i,
    output triple_t triple_o,
    output logic    rise_o
);

    logic s_4f_q, s_2f_q, s_f_q, d_f_q;

    // Sample stage plus one extra delay on clk_f for edge detection.
    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            s_4f_q <= 1'b0;
            s_2f_q <= 1'b0;
            s_f_q  <= 1'b0;
            d_f_q  <= 1'b0;
        end else begin
            s_4f_q <= clk_4f_i;
            s_2f_q <= clk_2f_i;
            s_f_q  <= clk_f_i;
            d_f_q  <= s_f_q;
        end
    end

    assign triple_o = {s_f_q, s_2f_q, s_4f_q};
    assign rise_o   = s_f_q & ~d_f_q;

endmodule

// File: rtl/clk_phase_checker.sv
// Receive-side monitor for clk_4f/clk_2f/clk_f: finds the clk_f rising edge, verifies
// VERIFY_PERIODS full periods of the 32-phase pattern, then reports lock and mismatches.
// Optional SEARCH timeout (stuck flag) is built when CLK_CHECK_TIMEOUT_EN is defined.
module clk_phase_checker
    import clk_check_pkg::*;
#(
    parameter int unsigned VERIFY_PERIODS = 2,
    parameter int unsigned ERR_W          = 8
`ifdef CLK_CHECK_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 128
`endif
) (
    input  logic               clk_32f,
    input  logic               reset,
    input  logic               clk_4f_in,
    input  logic               clk_2f_in,
    input  logic               clk_f_in,
    output logic               locked,
    output logic               err_pulse,
    output logic [ERR_W-1:0]   err_count,
    output logic [PHASE_W-1:0] phase
`ifdef CLK_CHECK_TIMEOUT_EN
    ,
    output logic               stuck
`endif
);

    localparam int unsigned VerifyCycles = VERIFY_PERIODS * PERIOD;
    localparam int unsigned VcntW        = $clog2(VerifyCycles + 1);

    triple_t triple;
    logic    rise;
    logic    match;

    state_e             state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [VcntW-1:0]   vcnt_q, vcnt_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    logic               err_pulse_q, err_pulse_d;

    clk_edge_sampler u_sampler (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .clk_4f_i (clk_4f_in),
        .clk_2f_i (clk_2f_in),
        .clk_f_i  (clk_f_in),
        .triple_o (triple),
        .rise_o   (rise)
    );

    assign match = (triple == expected_triple(phase_q));

    // Next-state for the search/verify/locked tracker, phase counter and error counter.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q + 1'b1;
        vcnt_d      = vcnt_q;
        err_cnt_d   = err_cnt_q;
        err_pulse_d = 1'b0;
        unique case (state_q)
            SEARCH: begin
                phase_d = '0;
                if (rise) begin
                    // The rise cycle itself is phase 0.
                    phase_d = PHASE_W'(1);
                    vcnt_d  = '0;
                    state_d = VERIFY;
                end
            end
            VERIFY: begin
                if (match) begin
                    vcnt_d = vcnt_q + 1'b1;
                    if (vcnt_q == VcntW'(VerifyCycles - 1)) begin
                        state_d = LOCKED;
                    end
                end else begin
                    phase_d = '0;
                    vcnt_d  = '0;
                    state_d = SEARCH;
                end
            end
            LOCKED: begin
                // A coincident rise is deliberately not reused: restart from SEARCH.
                if (!match) begin
                    err_pulse_d = 1'b1;
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                    phase_d = '0;
                    state_d = SEARCH;
                end
            end
            default: begin
                phase_d = '0;
                state_d = SEARCH;
            end
        endcase
    end

    // Tracker state registers.
    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            state_q     <= SEARCH;
            phase_q     <= '0;
            vcnt_q      <= '0;
            err_cnt_q   <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            vcnt_q      <= vcnt_d;
            err_cnt_q   <= err_cnt_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    assign locked    = (state_q == LOCKED);
    assign err_pulse = err_pulse_q;
    assign err_count = err_cnt_q;
    assign phase     = phase_q;

`ifdef CLK_CHECK_TIMEOUT_EN
    localparam int unsigned ScntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [ScntW-1:0] scnt_q, scnt_d;
    logic             stuck_q, stuck_d;

    // SEARCH dwell counter; stuck is sticky until a rise or reset.
    always_comb begin
        scnt_d  = '0;
        stuck_d = stuck_q;
        if (state_q == SEARCH) begin
            if (rise) begin
                stuck_d = 1'b0;
            end else begin
                scnt_d = (scnt_q == ScntW'(TIMEOUT_CYCLES)) ? scnt_q : scnt_q + 1'b1;
                if (scnt_q >= ScntW'(TIMEOUT_CYCLES - 1)) begin
                    stuck_d = 1'b1;
                end
            end
        end
    end

    // Timeout registers.
    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            scnt_q  <= '0;
            stuck_q <= 1'b0;
        end else begin
            scnt_q  <= scnt_d;
            stuck_q <= stuck_d;
        end
    end

    assign stuck = stuck_q;
`endif

endmodule

// File: tb/tb_clk_phase_checker.sv
// Self-checking bench for clk_phase_checker: ideal/offset/noisy clock source, behavioural model,
// per-cycle compare plus literal checks. Build with CLK_CHECK_TIMEOUT_EN to cover the stuck flag.
module tb_clk_phase_checker;

    localparam int VerifyPeriods = 2;
    localparam int ErrW          = 8;
    localparam int ErrMax        = (1 << ErrW) - 1;
    localparam int TimeoutCycles = 128;

    logic            clk_32f;
    logic            reset;
    logic            clk_4f_in, clk_2f_in, clk_f_in;
    logic            locked, err_pulse;
    logic [ErrW-1:0] err_count;
    logic [4:0]      phase;
`ifdef CLK_CHECK_TIMEOUT_EN
    logic            stuck;
`endif

    clk_phase_checker #(
        .VERIFY_PERIODS (VerifyPeriods),
        .ERR_W          (ErrW)
`ifdef CLK_CHECK_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (TimeoutCycles)
`endif
    ) dut (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .clk_4f_in (clk_4f_in),
        .clk_2f_in (clk_2f_in),
        .clk_f_in  (clk_f_in),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .phase     (phase)
`ifdef CLK_CHECK_TIMEOUT_EN
        ,
        .stuck     (stuck)
`endif
    );

    initial clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    int total = 0;
    int bad   = 0;

    // Source generator state
    int g = 0;
    int offset_mode = 0;
    int static_mode = 1;
    int last_f = 0;
    int ecnt = 0;
    int pulses = 0;
    bit rise_at [0:99999];

    // Behavioural model state
    int       m_state = 0;   // 0 searching, 1 verifying, 2 locked
    int       m_phase = 0;
    int       m_vcnt = 0;
    int       m_err = 0;
    int       m_pulse = 0;
    int       m_stuck = 0;
    int       m_scnt = 0;
    logic [2:0] m_samp = '0;
    logic     m_prevf = 1'b0;

    // Ideal {f, 2f, 4f} levels at position p of a 32-cycle clk_f period.
    function automatic logic [2:0] ideal(input int p);
        logic [2:0] t;
        t[2] = ((p % 32) < 16);
        t[1] = ((p % 16) < 8);
        t[0] = ((p % 8) < 4);
        return t;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d (edge %0d)", name, act, exp, ecnt);
        end
    endtask

    task automatic model_step();
        logic       rise;
        logic       match;
        logic [2:0] nxt;
        nxt = {clk_f_in, clk_2f_in, clk_4f_in};
        ecnt++;
        if (!reset) begin
            m_state = 0; m_phase = 0; m_vcnt = 0; m_err = 0; m_pulse = 0;
            m_stuck = 0; m_scnt = 0; m_samp = '0; m_prevf = 1'b0;
            return;
        end
        rise  = m_samp[2] && !m_prevf;
        match = (m_samp == ideal(m_phase));
        m_pulse = 0;
        if (m_state == 0) begin
            if (rise) begin
                m_stuck = 0;
                m_scnt  = 0;
            end else begin
                m_scnt++;
                if (m_scnt >= TimeoutCycles) m_stuck = 1;
            end
        end else begin
            m_scnt = 0;
        end
        case (m_state)
            0: begin
                if (rise) begin
                    m_state = 1; m_phase = 1; m_vcnt = 0;
                end else begin
                    m_phase = 0;
                end
            end
            1: begin
                if (match) begin
                    m_phase = (m_phase + 1) % 32;
                    m_vcnt++;
                    if (m_vcnt == VerifyPeriods * 32) m_state = 2;
                end else begin
                    m_state = 0; m_phase = 0;
                end
            end
            default: begin
                if (match) begin
                    m_phase = (m_phase + 1) % 32;
                end else begin
                    m_pulse = 1;
                    if (m_err < ErrMax) m_err++;
                    m_state = 0; m_phase = 0;
                end
            end
        endcase
        m_prevf = m_samp[2];
        m_samp  = nxt;
    endtask

    // Model advances on every active edge.
    initial begin
        forever begin
            @(posedge clk_32f);
            model_step();
        end
    end

    // Compare DUT against the model on every falling edge once reset has been seen.
    initial begin
        @(posedge clk_32f);
        forever begin
            @(negedge clk_32f);
            check("locked", int'(locked), int'(m_state == 2));
            check("err_pulse", int'(err_pulse), m_pulse);
            check("err_count", int'(err_count), m_err);
            check("phase", int'(phase), m_phase);
`ifdef CLK_CHECK_TIMEOUT_EN
            check("stuck", int'(stuck), m_stuck);
`endif
        end
    end

    // Drive one cycle of source clocks (optionally corrupted) and advance past one edge.
    task automatic tick(input logic [2:0] flip);
        logic [2:0] t;
        t = ideal(g);
        if (offset_mode != 0) t[0] = (((g + 4) % 8) < 4);
        t = t ^ flip;
        if (static_mode != 0) t = '0;
        {clk_f_in, clk_2f_in, clk_4f_in} = t;
        if (t[2] && last_f == 0 && ecnt + 1 < 100000) rise_at[ecnt + 1] = 1'b1;
        last_f = int'(t[2]);
        g = (g + 1) % 32;
        @(negedge clk_32f);
        if (err_pulse) pulses++;
    endtask

    // Run until the DUT locks; the rise that started verification must be 65 edges earlier.
    task automatic wait_lock();
        int n;
        n = 0;
        do begin
            tick(3'b000);
            n++;
        end while (!locked && n < 400);
        check("lock_wait", int'(locked), 1);
        if (locked && ecnt >= 65) check("lock_after_rise", int'(rise_at[ecnt - 65]), 1);
    endtask

    initial begin
        int nlock;
        reset = 1'b0;
        {clk_f_in, clk_2f_in, clk_4f_in} = 3'b000;
        @(negedge clk_32f);
        repeat (3) tick(3'b000);
        check("rst_locked", int'(locked), 0);
        check("rst_phase", int'(phase), 0);
        check("rst_err_count", int'(err_count), 0);
        check("rst_err_pulse", int'(err_pulse), 0);

        // Static clocks: must stay searching with phase held at 0.
        reset = 1'b1;
        repeat (127) tick(3'b000);
`ifdef CLK_CHECK_TIMEOUT_EN
        check("stuck_before_timeout", int'(stuck), 0);
`endif
        tick(3'b000);
`ifdef CLK_CHECK_TIMEOUT_EN
        check("stuck_at_timeout", int'(stuck), 1);
`endif
        check("static_locked", int'(locked), 0);
        check("static_phase", int'(phase), 0);

        // Ideal source starting mid-low so the first rise is clean.
        static_mode = 0;
        g = 20;
        wait_lock();
        check("ideal_err_count", int'(err_count), 0);
`ifdef CLK_CHECK_TIMEOUT_EN
        check("stuck_cleared", int'(stuck), 0);
`endif

        // Force clk_2f high at phase 10 while locked.
        pulses = 0;
        while (g != 10) tick(3'b000);
        check("locked_before_inject", int'(locked), 1);
        tick(3'b010);
        repeat (3) tick(3'b000);
        check("inject_err_count", int'(err_count), 1);
        check("inject_unlocked", int'(locked), 0);
        check("inject_pulses", pulses, 1);
        wait_lock();

        // Two more errors, then reset while locked.
        repeat (2) begin
            repeat ($urandom_range(0, 31)) tick(3'b000);
            tick(3'b001);
            repeat (2) tick(3'b000);
            wait_lock();
        end
        check("pre_reset_err_count", int'(err_count), 3);
        reset = 1'b0;
        tick(3'b000);
        reset = 1'b1;
        check("midlock_rst_locked", int'(locked), 0);
        check("midlock_rst_err_count", int'(err_count), 0);
        check("midlock_rst_phase", int'(phase), 0);

        // clk_4f offset by 4 cycles: never locks, no errors counted.
        offset_mode = 1;
        nlock = 0;
        repeat (200) begin
            tick(3'b000);
            if (locked) nlock++;
        end
        check("offset_lock_cycles", nlock, 0);
        check("offset_err_count", int'(err_count), 0);
        offset_mode = 0;

        // 300 locked-state errors with random timing/masks plus search-time noise.
        pulses = 0;
        for (int i = 0; i < 300; i++) begin
            wait_lock();
            repeat ($urandom_range(0, 20)) tick(3'b000);
            tick(3'($urandom_range(1, 7)));
            repeat (2) tick(3'b000);
            if ($urandom_range(0, 3) == 0 && m_state == 0) tick(3'($urandom_range(1, 7)));
        end
        repeat (2) tick(3'b000);
        check("sat_err_count", int'(err_count), 255);
        check("sat_pulses", pulses, 300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clk_phase_checker.md
# clk_phase_checker

Receive-side monitor for the divided clocks clk_4f, clk_2f and clk_f, all derived from clk_32f. It samples the three clocks in the clk_32f domain, finds the clk_f rising edge, and tracks the expected 32-cycle phase pattern. It reports lock, single-cycle error pulses and a saturating error count. It sits at the consumer end of the clock tree, beside the word-width converters, and gates their start-up on a verified clock relationship.

## Interface
- VERIFY_PERIODS, 2: number of full clk_f periods (32 clk_32f cycles each) that must match before lock.
- ERR_W, 8: width of the error counter.
- TIMEOUT_CYCLES, 128: limit on SEARCH cycles before the stuck flag sets. Used only with CLK_CHECK_TIMEOUT_EN.
- clk_32f, input, 1: reference clock. All logic uses its rising edge.
- reset, input, 1: reset. Synchronous, active-low.
- clk_4f_in, input, 1: divided clock under check, nominal period 8 clk_32f cycles.
- clk_2f_in, input, 1: divided clock under check, nominal period 16.
- clk_f_in, input, 1: divided clock under check, nominal period 32.
- locked, output, 1: high while in LOCKED.
- err_pulse, output, 1: one-cycle pulse on each mismatch seen in LOCKED.
- err_count, output, ERR_W: count of LOCKED mismatches. Saturates at all-ones.
- phase, output, 5: current phase counter p.
- stuck, output, 1: SEARCH timeout flag. Only present with CLK_CHECK_TIMEOUT_EN.

## Operation
- Sample stage: the inputs are registered into s_4f, s_2f and s_f, and s_f is delayed once more into d_f. The inputs come from the same clk_32f, so no synchronizers are used.
- rise = s_f & ~d_f.
- Phase counter p is 5 bits. It increments every cycle and wraps from 31 to 0.
- Expected sampled triple at phase p: {f, 2f, 4f} = {~p[4], ~p[3], ~p[2]}.
  - p=0 expects 111.
  - p=31 expects 000.
- match is true when the sampled triple equals the expected triple.
- States: SEARCH, VERIFY, LOCKED.
- SEARCH:
  - p holds at 0.
  - On rise: set p to 1 (the rise cycle is phase 0), clear the verify counter, go to VERIFY.
- VERIFY:
  - match: p increments and the verify counter increments.
  - Verify counter reaches VERIFY_PERIODS*32 matched cycles: go to LOCKED.
  - Any mismatch: go to SEARCH and set p to 0. err_count does not change.
- LOCKED:
  - Every cycle is compared.
  - Mismatch: pulse err_pulse, increment err_count (saturating), go to SEARCH.
- Simultaneous events:
  - A rise coincident with a mismatch in LOCKED: the mismatch takes priority. Go to SEARCH. That rise is not reused.
  - err_count at all-ones plus a new error: err_pulse still fires and the count holds.
- Reset (reset==0 on a clk_32f edge):
  - state=SEARCH, p=0.
  - s_4f, s_2f, s_f, d_f = 0.
  - locked=0, err_pulse=0, err_count=0, stuck=0.
  - Reset mid-lock clears everything, including err_count.
- Clocks held static: no rise, so the block stays in SEARCH indefinitely.

## Timing
- Input to sample register: 1 cycle.
- rise is valid in the cycle after the s_f 0→1 transition is registered.
- locked rises on the clock edge that completes the last matched VERIFY cycle. For an ideal source, that is rise + VERIFY_PERIODS*32 cycles.
- Mismatch to outputs: err_pulse and the err_count update are both registered.
  - They appear on the edge after the mismatched sample is compared.
  - locked falls on that same edge.
- err_pulse is never high for two consecutive cycles from a single mismatch, because the block leaves LOCKED immediately.

## Configuration
- CLK_CHECK_TIMEOUT_EN defined:
  - A SEARCH cycle counter runs while in SEARCH.
  - Reaching TIMEOUT_CYCLES sets stuck, which is sticky until rise or reset.
  - The counter clears when the block leaves SEARCH.
- CLK_CHECK_TIMEOUT_EN undefined: the stuck port, the SEARCH counter and TIMEOUT_CYCLES are absent.

## Structure
- Package clk_check_pkg:
  - state enum {SEARCH, VERIFY, LOCKED}.
  - PHASE_W=5 and PERIOD=32.
  - Function expected_triple(p).
- Sub-module clk_edge_sampler: sample registers, d_f and the rise detect. The FSM, phase counter and error counter stay in the top level.

## Test plan
- Ideal clk_generator source after reset release → locked=1 exactly 64 cycles after the first rise, err_count=0, phase tracks 0..31.
- Force clk_2f_in to 1 for one cycle at p=10 while locked → err_pulse once, err_count=1, locked=0, re-lock 64 cycles after the next rise.
- Source offset by 4 cycles between clk_4f and clk_f → mismatch in VERIFY, never locked, err_count stays 0.
- 300 injected errors with ERR_W=8 → err_count saturates at 255, err_pulse fires on each error.
- reset=0 for one cycle while locked with err_count=3 → next cycle locked=0, err_count=0, phase=0, state SEARCH.
- With CLK_CHECK_TIMEOUT_EN and all clocks held 0 → stuck=1 after 128 cycles, then clears on the first rise.
